ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have inputs id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch (1 each) and id_ALUOp (2): decoded control bundle for the instruction in ID.
REQ-004 SHALL have inputs id_rs, id_rt, id_rd, 5 each: register fields of the instruction in ID.
REQ-005 SHALL have input mem_zero, 1: ALU zero flag of the instruction in MEM.
REQ-006 SHALL have outputs ex_RegDst, ex_ALUSrc (1), ex_ALUOp (2): EX-stage controls.
REQ-007 SHALL have outputs mem_MemRead, mem_MemWrite, mem_Branch (1): MEM-stage controls.
REQ-008 SHALL have outputs wb_MemtoReg, wb_RegWrite (1) and wb_dst (5): WB-stage controls and destination register.
REQ-009 SHALL have outputs ex_rt (5) and mem_dst (5): destinations for forwarding and hazard logic.
REQ-010 SHALL have outputs stall (1; holds PC and IF/ID) and pc_src (1; redirects PC, flushes IF/ID).

Function
REQ-011 SHALL be a 3-stage control pipeline ID/EX -> EX/MEM -> MEM/WB, each stage one register.
REQ-012 SHALL register id_rt and id_rd into EX; EX destination = ex_RegDst ? ex_rd : ex_rt, registered into mem_dst, then into wb_dst.
REQ-013 SHALL drive pc_src = mem_Branch & mem_zero, combinationally.
REQ-014 SHALL drive stall = ex_MemRead & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & ~pc_src, combinationally.
REQ-015 SHALL on stall load an all-zero bundle (bubble) into ID/EX while EX/MEM and MEM/WB advance normally; one bubble per load-use hazard.
REQ-016 SHALL on pc_src load all-zero bundles into ID/EX and EX/MEM; MEM/WB receives the branch's own bundle.
REQ-017 SHALL give pc_src priority over stall in the same cycle; stall forced 0.
REQ-018 SHALL otherwise pass the ID bundle to EX, EX-stage MEM/WB fields to MEM, and MEM-stage WB fields to WB each cycle; latency ID->WB exactly 3 cycles.
REQ-019 SHALL keep destination fields in bubbled stages at 0.
REQ-020 SHALL treat all-zero bundle as NOP: no register write, no memory access, no branch.

Reset
REQ-021 SHALL on reset assertion immediately clear all pipeline registers to 0 regardless of clk.
REQ-022 SHALL hold every output at 0 while reset is high (stall and pc_src follow from cleared state).
REQ-023 SHALL resume with the first rising edge after deassertion; in-flight instructions at reset are discarded.

Structure
REQ-024 SHALL import opcode constants (R-type 000000, beq 000100, lw 100011, sw 101011, j 000010), ALUOp encodings (00 add, 01 sub, 10 funct) and bundle widths from shared package ctrl_pkg.
REQ-025 SHALL implement REQ-014 in sub-module hazard_detect, inputs ex_MemRead, ex_rt, id_rs, id_rt, pc_src; output stall.

Verification
REQ-026 SHALL cover: R-type bundle (RegDst=1, RegWrite=1, ALUOp=10, rd=5) in ID, no hazards -> wb_RegWrite=1, wb_dst=5 exactly 3 cycles later.
REQ-027 SHALL cover: lw rt=8 then add rs=8 next cycle -> stall=1 one cycle, ex bundle zero following cycle, add reaches EX one cycle late.
REQ-028 SHALL cover: lw rt=0 then add rs=0 -> stall stays 0.
REQ-029 SHALL cover: beq in MEM with mem_zero=1 -> pc_src=1; next cycle EX and MEM bundles zero; beq with mem_zero=0 -> no flush.
REQ-030 SHALL cover: load-use hazard coincident with pc_src=1 -> stall=0, flush per REQ-016.
REQ-031 SHALL cover: reset asserted mid-stream between edges -> all outputs 0 immediately; after release, new sw bundle yields mem_MemWrite=1 two cycles later.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants and stage-bundle types for the 3-stage control pipeline.
// Opcode/ALUOp encodings are the common vocabulary for decode and pipeline logic.
package ctrl_pkg;

  localparam int REG_W   = 5;
  localparam int ALUOP_W = 2;
  localparam int OPC_W   = 6;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               mem_to_reg;
    logic               reg_write;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
  } ex_stage_t;

  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] dst;
  } mem_stage_t;

  typedef struct packed {
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] dst;
  } wb_stage_t;

  // Destination register chosen in EX: rd for R-type, rt otherwise.
  function automatic logic [REG_W-1:0] ex_dst(input ex_stage_t s);
    return s.reg_dst ? s.rd : s.rt;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: requests a one-cycle stall unless a taken branch
// is already flushing the younger instructions.
module hazard_detect
  import ctrl_pkg::*;
(
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             pc_src,
  output logic             stall
);

  // Register 0 is hardwired, so a load into it never creates a dependency.
  always_comb begin
    stall = ex_MemRead
          & (ex_rt != 5'd0)
          & ((ex_rt == id_rs) | (ex_rt == id_rt))
          & ~pc_src;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use bubbling and
// taken-branch flushing; pc_src outranks stall.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               id_RegDst,
  input  logic               id_ALUSrc,
  input  logic               id_MemtoReg,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_Branch,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               mem_zero,
  output logic               ex_RegDst,
  output logic               ex_ALUSrc,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_Branch,
  output logic               wb_MemtoReg,
  output logic               wb_RegWrite,
  output logic [REG_W-1:0]   wb_dst,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   mem_dst,
  output logic               stall,
  output logic               pc_src
);

  ex_stage_t  ex_d, ex_q;
  mem_stage_t mem_d, mem_q;
  wb_stage_t  wb_d, wb_q;
  ex_stage_t  id_bundle_s;

  assign pc_src = mem_q.branch & mem_zero;

  hazard_detect u_hazard (
    .ex_MemRead (ex_q.mem_read),
    .ex_rt      (ex_q.rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .pc_src     (pc_src),
    .stall      (stall)
  );

  always_comb begin
    id_bundle_s = '{reg_dst:    id_RegDst,
                    alu_src:    id_ALUSrc,
                    alu_op:     id_ALUOp,
                    mem_read:   id_MemRead,
                    mem_write:  id_MemWrite,
                    branch:     id_Branch,
                    mem_to_reg: id_MemtoReg,
                    reg_write:  id_RegWrite,
                    rt:         id_rt,
                    rd:         id_rd};
  end

  // Next-state: the branch in MEM always retires into WB, even when it flushes.
  always_comb begin
    ex_d  = '0;
    mem_d = '0;
    wb_d  = '{mem_to_reg: mem_q.mem_to_reg,
              reg_write:  mem_q.reg_write,
              dst:        mem_q.dst};
    if (pc_src) begin
      ex_d  = '0;
      mem_d = '0;
    end else begin
      mem_d = '{mem_read:   ex_q.mem_read,
                mem_write:  ex_q.mem_write,
                branch:     ex_q.branch,
                mem_to_reg: ex_q.mem_to_reg,
                reg_write:  ex_q.reg_write,
                dst:        ex_dst(ex_q)};
      if (stall) begin
        ex_d = '0;
      end else begin
        ex_d = id_bundle_s;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_RegDst    = ex_q.reg_dst;
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_ALUOp     = ex_q.alu_op;
  assign ex_rt        = ex_q.rt;
  assign mem_MemRead  = mem_q.mem_read;
  assign mem_MemWrite = mem_q.mem_write;
  assign mem_Branch   = mem_q.branch;
  assign mem_dst      = mem_q.dst;
  assign wb_MemtoReg  = wb_q.mem_to_reg;
  assign wb_RegWrite  = wb_q.reg_write;
  assign wb_dst       = wb_q.dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe: latency, load-use stall,
// branch flush, stall/flush priority and asynchronous reset.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
  logic       id_MemRead, id_MemWrite, id_Branch;
  logic [1:0] id_ALUOp;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       mem_zero;
  logic       ex_RegDst, ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic       mem_MemRead, mem_MemWrite, mem_Branch;
  logic       wb_MemtoReg, wb_RegWrite;
  logic [4:0] wb_dst, ex_rt, mem_dst;
  logic       stall, pc_src;

  int n_tests = 0;
  int n_fail  = 0;

  ctrl_pipe dut (
    .clk(clk), .reset(reset),
    .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_Branch(mem_Branch),
    .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite), .wb_dst(wb_dst),
    .ex_rt(ex_rt), .mem_dst(mem_dst), .stall(stall), .pc_src(pc_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic rd_sel, input logic asrc, input logic m2r,
                            input logic rw, input logic mr, input logic mw,
                            input logic br, input logic [1:0] aop,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_RegDst = rd_sel; id_ALUSrc = asrc; id_MemtoReg = m2r; id_RegWrite = rw;
    id_MemRead = mr; id_MemWrite = mw; id_Branch = br; id_ALUOp = aop;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic set_nop();
    set_bundle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    set_bundle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, rs, rt, rd);
  endtask

  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_bundle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, rs, rt, 5'd0);
  endtask

  task automatic set_beq(input logic [4:0] rs, input logic [4:0] rt);
    set_bundle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, rs, rt, 5'd0);
  endtask

  task automatic set_sw(input logic [4:0] rs, input logic [4:0] rt);
    set_bundle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, rs, rt, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    mem_zero = 1'b0;
    set_nop();
    #2;
    chk("rst_wb_regwrite", {7'd0, wb_RegWrite}, 8'h00);
    chk("rst_stall_pcsrc", {6'd0, stall, pc_src}, 8'h00);
    tick();
    reset = 1'b0;

    // R-type rd=5 reaches WB exactly three edges later
    set_rtype(5'd1, 5'd2, 5'd5);
    tick();
    set_nop();
    chk("rt_ex_ctrl", {5'd0, ex_RegDst, ex_ALUOp}, 8'h06);
    chk("rt_wb_early", {7'd0, wb_RegWrite}, 8'h00);
    tick();
    chk("rt_mem_dst", {3'd0, mem_dst}, 8'h05);
    chk("rt_wb_still_early", {7'd0, wb_RegWrite}, 8'h00);
    tick();
    chk("rt_wb_regwrite", {7'd0, wb_RegWrite}, 8'h01);
    chk("rt_wb_dst", {3'd0, wb_dst}, 8'h05);

    // lw rt=8 followed by add rs=8: one bubble, add enters EX late
    set_lw(5'd1, 5'd8);
    tick();
    set_rtype(5'd8, 5'd3, 5'd9);
    #1;
    chk("lu_stall", {7'd0, stall}, 8'h01);
    tick();
    chk("lu_bubble_ex", {3'd0, ex_RegDst, ex_ALUOp, ex_ALUSrc, 1'b0}, 8'h00);
    chk("lu_bubble_rt", {3'd0, ex_rt}, 8'h00);
    chk("lu_mem_lw", {2'd0, mem_MemRead, mem_dst}, 8'h28);
    chk("lu_stall_once", {7'd0, stall}, 8'h00);
    tick();
    set_nop();
    chk("lu_add_ex", {5'd0, ex_RegDst, ex_ALUOp}, 8'h06);
    chk("lu_add_rt", {3'd0, ex_rt}, 8'h03);
    tick();
    tick();

    // lw into r0 never stalls
    set_lw(5'd1, 5'd0);
    tick();
    set_rtype(5'd0, 5'd4, 5'd6);
    #1;
    chk("r0_no_stall", {7'd0, stall}, 8'h00);
    tick();
    set_nop();
    chk("r0_add_ex", {5'd0, ex_RegDst, ex_ALUOp}, 8'h06);
    tick();
    tick();
    tick();

    // taken beq flushes EX and MEM, beq itself retires to WB
    set_beq(5'd1, 5'd2);
    tick();
    set_rtype(5'd3, 5'd4, 5'd7);
    tick();
    set_rtype(5'd5, 5'd6, 5'd10);
    mem_zero = 1'b1;
    #1;
    chk("br_pc_src", {6'd0, pc_src, stall}, 8'h02);
    tick();
    mem_zero = 1'b0;
    set_nop();
    chk("br_flush_ex", {4'd0, ex_RegDst, ex_ALUSrc, ex_ALUOp}, 8'h00);
    chk("br_flush_mem", {mem_MemRead, mem_MemWrite, mem_Branch, mem_dst}, 8'h00);
    chk("br_wb_own", {2'd0, wb_RegWrite, wb_dst}, 8'h02);
    tick();
    tick();

    // not-taken beq: no flush
    set_beq(5'd1, 5'd2);
    tick();
    set_rtype(5'd3, 5'd4, 5'd11);
    tick();
    set_nop();
    #1;
    chk("nt_pc_src", {6'd0, mem_Branch, pc_src}, 8'h02);
    tick();
    chk("nt_mem_dst", {3'd0, mem_dst}, 8'h0b);
    tick();
    tick();

    // load-use coincident with taken branch: flush wins, no stall
    set_beq(5'd1, 5'd2);
    tick();
    set_lw(5'd1, 5'd8);
    tick();
    set_rtype(5'd8, 5'd3, 5'd9);
    mem_zero = 1'b1;
    #1;
    chk("co_pc_stall", {6'd0, pc_src, stall}, 8'h02);
    tick();
    mem_zero = 1'b0;
    set_nop();
    chk("co_flush_ex", {2'd0, ex_RegDst, ex_rt}, 8'h00);
    chk("co_flush_mem", {2'd0, mem_MemRead, mem_dst}, 8'h00);
    chk("co_wb_beq", {2'd0, wb_RegWrite, wb_dst}, 8'h02);

    // asynchronous reset between edges
    set_rtype(5'd1, 5'd2, 5'd5);
    tick();
    set_lw(5'd1, 5'd9);
    tick();
    set_rtype(5'd9, 5'd9, 5'd12);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_ex", {2'd0, ex_RegDst, ex_ALUSrc, ex_ALUOp, 2'd0}, 8'h00);
    chk("ar_rt_memdst", {ex_rt[3:0], mem_dst[3:0]}, 8'h00);
    chk("ar_mem_ctrl", {5'd0, mem_MemRead, mem_MemWrite, mem_Branch}, 8'h00);
    chk("ar_wb", {1'b0, wb_MemtoReg, wb_RegWrite, wb_dst}, 8'h00);
    chk("ar_stall_pc", {6'd0, stall, pc_src}, 8'h00);
    tick();
    reset = 1'b0;
    set_sw(5'd1, 5'd3);
    tick();
    set_nop();
    chk("sw_mem_early", {7'd0, mem_MemWrite}, 8'h00);
    chk("sw_discard", {2'd0, wb_RegWrite, wb_dst}, 8'h00);
    tick();
    chk("sw_mem_write", {7'd0, mem_MemWrite}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
